// File: rtl/axi4_lite_arbiter.sv
// rtl/axi4_lite_arbiter.sv - two-master to one-slave AXI4-Lite arbiter, independent write/read grants
module axi4_lite_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] S0_AXI_AWADDR,
    input  logic        S0_AXI_AWVALID,
    output logic        S0_AXI_AWREADY,
    input  logic [31:0] S0_AXI_WDATA,
    input  logic [3:0]  S0_AXI_WSTRB,
    input  logic        S0_AXI_WVALID,
    output logic        S0_AXI_WREADY,
    output logic [1:0]  S0_AXI_BRESP,
    output logic        S0_AXI_BVALID,
    input  logic        S0_AXI_BREADY,
    input  logic [31:0] S0_AXI_ARADDR,
    input  logic        S0_AXI_ARVALID,
    output logic        S0_AXI_ARREADY,
    output logic [31:0] S0_AXI_RDATA,
    output logic [1:0]  S0_AXI_RRESP,
    output logic        S0_AXI_RVALID,
    input  logic        S0_AXI_RREADY,
    input  logic [31:0] S1_AXI_AWADDR,
    input  logic        S1_AXI_AWVALID,
    output logic        S1_AXI_AWREADY,
    input  logic [31:0] S1_AXI_WDATA,
    input  logic [3:0]  S1_AXI_WSTRB,
    input  logic        S1_AXI_WVALID,
    output logic        S1_AXI_WREADY,
    output logic [1:0]  S1_AXI_BRESP,
    output logic        S1_AXI_BVALID,
    input  logic        S1_AXI_BREADY,
    input  logic [31:0] S1_AXI_ARADDR,
    input  logic        S1_AXI_ARVALID,
    output logic        S1_AXI_ARREADY,
    output logic [31:0] S1_AXI_RDATA,
    output logic [1:0]  S1_AXI_RRESP,
    output logic        S1_AXI_RVALID,
    input  logic        S1_AXI_RREADY,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [1:0]  WGNT,
    output logic [1:0]  RGNT
);

    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic {R_IDLE, R_BUSY} r_state_t;

    w_state_t    r_wstate, w_wstate_nxt;
    r_state_t    r_rstate, w_rstate_nxt;
    logic [1:0]  r_wgnt, w_wgnt_nxt, r_rgnt, w_rgnt_nxt;
    logic        r_wlast, w_wlast_nxt, r_rlast, w_rlast_nxt;
    logic        r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt, r_ar_done, w_ar_done_nxt;

    logic        w_wreq0, w_wreq1, w_wpick, w_rreq0, w_rreq1, w_rpick;
    logic        w_wbusy, w_rbusy, w_wsel, w_rsel;
    logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_wreq0 = S0_AXI_AWVALID | S0_AXI_WVALID;
    assign w_wreq1 = S1_AXI_AWVALID | S1_AXI_WVALID;
    assign w_rreq0 = S0_AXI_ARVALID;
    assign w_rreq1 = S1_AXI_ARVALID;

    // Tie goes to the master not served last (FAIR) or to master 0; a lone requester always wins.
    assign w_wpick = (w_wreq0 & w_wreq1) ? (FAIR ? ~r_wlast : 1'b0) : w_wreq1;
    assign w_rpick = (w_rreq0 & w_rreq1) ? (FAIR ? ~r_rlast : 1'b0) : w_rreq1;

    assign w_wbusy = (r_wstate == W_BUSY);
    assign w_rbusy = (r_rstate == R_BUSY);
    assign w_wsel  = r_wgnt[1];
    assign w_rsel  = r_rgnt[1];
    assign WGNT    = r_wgnt;
    assign RGNT    = r_rgnt;

    assign M_AXI_AWADDR  = w_wbusy ? (w_wsel ? S1_AXI_AWADDR : S0_AXI_AWADDR) : 32'h0;
    assign M_AXI_AWVALID = w_wbusy & ~r_aw_done & (w_wsel ? S1_AXI_AWVALID : S0_AXI_AWVALID);
    assign M_AXI_WDATA   = w_wbusy ? (w_wsel ? S1_AXI_WDATA : S0_AXI_WDATA) : 32'h0;
    assign M_AXI_WSTRB   = w_wbusy ? (w_wsel ? S1_AXI_WSTRB : S0_AXI_WSTRB) : 4'h0;
    assign M_AXI_WVALID  = w_wbusy & ~r_w_done & (w_wsel ? S1_AXI_WVALID : S0_AXI_WVALID);
    assign M_AXI_BREADY  = w_wbusy & (w_wsel ? S1_AXI_BREADY : S0_AXI_BREADY);

    assign S0_AXI_AWREADY = r_wgnt[0] & ~r_aw_done & M_AXI_AWREADY;
    assign S0_AXI_WREADY  = r_wgnt[0] & ~r_w_done & M_AXI_WREADY;
    assign S0_AXI_BVALID  = r_wgnt[0] & M_AXI_BVALID;
    assign S0_AXI_BRESP   = r_wgnt[0] ? M_AXI_BRESP : 2'b00;
    assign S1_AXI_AWREADY = r_wgnt[1] & ~r_aw_done & M_AXI_AWREADY;
    assign S1_AXI_WREADY  = r_wgnt[1] & ~r_w_done & M_AXI_WREADY;
    assign S1_AXI_BVALID  = r_wgnt[1] & M_AXI_BVALID;
    assign S1_AXI_BRESP   = r_wgnt[1] ? M_AXI_BRESP : 2'b00;

    assign M_AXI_ARADDR  = w_rbusy ? (w_rsel ? S1_AXI_ARADDR : S0_AXI_ARADDR) : 32'h0;
    assign M_AXI_ARVALID = w_rbusy & ~r_ar_done & (w_rsel ? S1_AXI_ARVALID : S0_AXI_ARVALID);
    assign M_AXI_RREADY  = w_rbusy & (w_rsel ? S1_AXI_RREADY : S0_AXI_RREADY);

    assign S0_AXI_ARREADY = r_rgnt[0] & ~r_ar_done & M_AXI_ARREADY;
    assign S0_AXI_RVALID  = r_rgnt[0] & M_AXI_RVALID;
    assign S0_AXI_RDATA   = r_rgnt[0] ? M_AXI_RDATA : 32'h0;
    assign S0_AXI_RRESP   = r_rgnt[0] ? M_AXI_RRESP : 2'b00;
    assign S1_AXI_ARREADY = r_rgnt[1] & ~r_ar_done & M_AXI_ARREADY;
    assign S1_AXI_RVALID  = r_rgnt[1] & M_AXI_RVALID;
    assign S1_AXI_RDATA   = r_rgnt[1] ? M_AXI_RDATA : 32'h0;
    assign S1_AXI_RRESP   = r_rgnt[1] ? M_AXI_RRESP : 2'b00;

    assign w_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID & M_AXI_WREADY;
    assign w_b_hs  = M_AXI_BVALID & M_AXI_BREADY;
    assign w_ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign w_r_hs  = M_AXI_RVALID & M_AXI_RREADY;

    // Last-grant pointers reset to master 1 so master 0 takes the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_wgnt    <= 2'b00;
            r_rgnt    <= 2'b00;
            r_wlast   <= 1'b1;
            r_rlast   <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_rstate  <= w_rstate_nxt;
            r_wgnt    <= w_wgnt_nxt;
            r_rgnt    <= w_rgnt_nxt;
            r_wlast   <= w_wlast_nxt;
            r_rlast   <= w_rlast_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_ar_done <= w_ar_done_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_wgnt_nxt    = r_wgnt;
        w_wlast_nxt   = r_wlast;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        if (r_wstate == W_IDLE) begin
            if (w_wreq0 | w_wreq1) begin
                w_wstate_nxt = W_BUSY;
                w_wgnt_nxt   = w_wpick ? 2'b10 : 2'b01;
                w_wlast_nxt  = w_wpick;
            end
        end else begin
            if (w_aw_hs) w_aw_done_nxt = 1'b1;
            if (w_w_hs)  w_w_done_nxt  = 1'b1;
            if (w_b_hs) begin
                w_wstate_nxt  = W_IDLE;
                w_wgnt_nxt    = 2'b00;
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
            end
        end
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_rgnt_nxt    = r_rgnt;
        w_rlast_nxt   = r_rlast;
        w_ar_done_nxt = r_ar_done;
        if (r_rstate == R_IDLE) begin
            if (w_rreq0 | w_rreq1) begin
                w_rstate_nxt = R_BUSY;
                w_rgnt_nxt   = w_rpick ? 2'b10 : 2'b01;
                w_rlast_nxt  = w_rpick;
            end
        end else begin
            if (w_ar_hs) w_ar_done_nxt = 1'b1;
            if (w_r_hs) begin
                w_rstate_nxt  = R_IDLE;
                w_rgnt_nxt    = 2'b00;
                w_ar_done_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb/tb_axi4_lite_arbiter.sv - directed bench: instance 0 round-robin, instance 1 fixed priority
module tb_axi4_lite_arbiter;

    logic        clk;
    logic        resetn;

    logic [31:0] s_awaddr  [2][2];
    logic        s_awvalid [2][2];
    logic        s_awready [2][2];
    logic [31:0] s_wdata   [2][2];
    logic [3:0]  s_wstrb   [2][2];
    logic        s_wvalid  [2][2];
    logic        s_wready  [2][2];
    logic [1:0]  s_bresp   [2][2];
    logic        s_bvalid  [2][2];
    logic        s_bready  [2][2];
    logic [31:0] s_araddr  [2][2];
    logic        s_arvalid [2][2];
    logic        s_arready [2][2];
    logic [31:0] s_rdata   [2][2];
    logic [1:0]  s_rresp   [2][2];
    logic        s_rvalid  [2][2];
    logic        s_rready  [2][2];
    logic [1:0]  wgnt [2];
    logic [1:0]  rgnt [2];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
        logic [3:0]  m_wstrb;
        logic [1:0]  m_bresp, m_rresp;
        logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
        logic        m_arvalid, m_arready, m_rvalid, m_rready;
        logic        aw_have, w_have;
        logic [31:0] sl_addr, sl_data;
        logic [31:0] mem [16];
        int          n_aw = 0, n_w = 0, n_b = 0, n_s1_rdy = 0;
        logic [1:0]  wq [$];
        logic [1:0]  rq [$];
        logic [1:0]  wprev = 2'b00, rprev = 2'b00;

        axi4_lite_arbiter #(.FAIR(k == 0)) dut (
            .clk(clk), .resetn(resetn),
            .S0_AXI_AWADDR(s_awaddr[k][0]), .S0_AXI_AWVALID(s_awvalid[k][0]), .S0_AXI_AWREADY(s_awready[k][0]),
            .S0_AXI_WDATA(s_wdata[k][0]), .S0_AXI_WSTRB(s_wstrb[k][0]), .S0_AXI_WVALID(s_wvalid[k][0]),
            .S0_AXI_WREADY(s_wready[k][0]), .S0_AXI_BRESP(s_bresp[k][0]), .S0_AXI_BVALID(s_bvalid[k][0]),
            .S0_AXI_BREADY(s_bready[k][0]), .S0_AXI_ARADDR(s_araddr[k][0]), .S0_AXI_ARVALID(s_arvalid[k][0]),
            .S0_AXI_ARREADY(s_arready[k][0]), .S0_AXI_RDATA(s_rdata[k][0]), .S0_AXI_RRESP(s_rresp[k][0]),
            .S0_AXI_RVALID(s_rvalid[k][0]), .S0_AXI_RREADY(s_rready[k][0]),
            .S1_AXI_AWADDR(s_awaddr[k][1]), .S1_AXI_AWVALID(s_awvalid[k][1]), .S1_AXI_AWREADY(s_awready[k][1]),
            .S1_AXI_WDATA(s_wdata[k][1]), .S1_AXI_WSTRB(s_wstrb[k][1]), .S1_AXI_WVALID(s_wvalid[k][1]),
            .S1_AXI_WREADY(s_wready[k][1]), .S1_AXI_BRESP(s_bresp[k][1]), .S1_AXI_BVALID(s_bvalid[k][1]),
            .S1_AXI_BREADY(s_bready[k][1]), .S1_AXI_ARADDR(s_araddr[k][1]), .S1_AXI_ARVALID(s_arvalid[k][1]),
            .S1_AXI_ARREADY(s_arready[k][1]), .S1_AXI_RDATA(s_rdata[k][1]), .S1_AXI_RRESP(s_rresp[k][1]),
            .S1_AXI_RVALID(s_rvalid[k][1]), .S1_AXI_RREADY(s_rready[k][1]),
            .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
            .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
            .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
            .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
            .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready),
            .WGNT(wgnt[k]), .RGNT(rgnt[k])
        );

        // Register-bank slave: one write and one read outstanding, B/R one cycle after capture.
        assign m_awready = ~aw_have;
        assign m_wready  = ~w_have;
        assign m_arready = ~m_rvalid;

        always @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                aw_have <= 1'b0; w_have <= 1'b0; sl_addr <= 32'h0; sl_data <= 32'h0;
                m_bvalid <= 1'b0; m_bresp <= 2'b00; m_rvalid <= 1'b0; m_rdata <= 32'h0; m_rresp <= 2'b00;
                for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            end else begin
                if (m_awvalid && m_awready) begin aw_have <= 1'b1; sl_addr <= m_awaddr; end
                if (m_wvalid && m_wready) begin w_have <= 1'b1; sl_data <= m_wdata; end
                if (aw_have && w_have && !m_bvalid) begin
                    mem[sl_addr[5:2]] <= sl_data;
                    m_bvalid <= 1'b1;
                    m_bresp  <= (sl_addr == 32'hFC) ? 2'b10 : 2'b00;
                end
                if (m_bvalid && m_bready) begin m_bvalid <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0; end
                if (m_arvalid && m_arready) begin m_rvalid <= 1'b1; m_rdata <= mem[m_araddr[5:2]]; end
                if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            end
        end

        always @(negedge clk) begin
            if (m_awvalid && m_awready) n_aw <= n_aw + 1;
            if (m_wvalid && m_wready) n_w <= n_w + 1;
            if (m_bvalid && m_bready) n_b <= n_b + 1;
            if (s_awready[k][1] || s_wready[k][1] || s_bvalid[k][1]) n_s1_rdy <= n_s1_rdy + 1;
            if (wgnt[k] != 2'b00 && wprev == 2'b00) wq.push_back(wgnt[k]);
            if (rgnt[k] != 2'b00 && rprev == 2'b00) rq.push_back(rgnt[k]);
            wprev <= wgnt[k];
            rprev <= rgnt[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input int k, input int m, input logic [31:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly, output logic [1:0] resp, output bit ok);
        int n = 0;
        bit aw_left = 1'b1, w_left = 1'b1, aw_hs, w_hs, b_hs;
        resp = 2'b11;
        ok   = 1'b0;
        s_awaddr[k][m] = a; s_wdata[k][m] = d; s_wstrb[k][m] = 4'hF; s_bready[k][m] = 1'b1;
        s_awvalid[k][m] = (aw_dly == 0);
        s_wvalid[k][m]  = (w_dly == 0);
        while (!ok && n < 60) begin
            @(negedge clk);
            aw_hs = s_awvalid[k][m] && s_awready[k][m];
            w_hs  = s_wvalid[k][m] && s_wready[k][m];
            b_hs  = s_bvalid[k][m] && s_bready[k][m];
            if (b_hs) resp = s_bresp[k][m];
            @(posedge clk);
            #1;
            n++;
            if (aw_hs) aw_left = 1'b0;
            if (w_hs) w_left = 1'b0;
            s_awvalid[k][m] = aw_left && (n >= aw_dly);
            s_wvalid[k][m]  = w_left && (n >= w_dly);
            if (b_hs) ok = 1'b1;
        end
        s_awvalid[k][m] = 1'b0; s_wvalid[k][m] = 1'b0; s_bready[k][m] = 1'b0;
    endtask

    task automatic do_read(input int k, input int m, input logic [31:0] a,
                           output logic [31:0] d, output bit ok);
        int n = 0;
        bit ar_hs, r_hs;
        d  = 32'h0;
        ok = 1'b0;
        s_araddr[k][m] = a; s_arvalid[k][m] = 1'b1; s_rready[k][m] = 1'b1;
        while (!ok && n < 60) begin
            @(negedge clk);
            ar_hs = s_arvalid[k][m] && s_arready[k][m];
            r_hs  = s_rvalid[k][m] && s_rready[k][m];
            if (r_hs) d = s_rdata[k][m];
            @(posedge clk);
            #1;
            n++;
            if (ar_hs) s_arvalid[k][m] = 1'b0;
            if (r_hs) ok = 1'b1;
        end
        s_arvalid[k][m] = 1'b0; s_rready[k][m] = 1'b0;
    endtask

    logic [31:0] rd0 [3];
    logic [31:0] rd1 [3];
    bit          okr0 [3];
    bit          okr1 [3];
    logic [1:0]  wr0 [3];
    logic [1:0]  wr1 [3];

    initial begin
        logic [1:0]  resp_a, resp_b;
        logic [31:0] rdat;
        bit          ok_a, ok_b;
        int          qs, c_aw, c_w, c_b, c_s1;

        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) begin
                s_awaddr[k][m] = 32'h0; s_awvalid[k][m] = 1'b0; s_wdata[k][m] = 32'h0; s_wstrb[k][m] = 4'h0;
                s_wvalid[k][m] = 1'b0; s_bready[k][m] = 1'b0; s_araddr[k][m] = 32'h0;
                s_arvalid[k][m] = 1'b0; s_rready[k][m] = 1'b0;
            end

        // Reset with requests already asserted: nothing may leak through.
        resetn = 1'b0;
        s_awvalid[0][0] = 1'b1; s_wvalid[0][0] = 1'b1; s_arvalid[0][1] = 1'b1; s_bready[0][0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wgnt", 32'(wgnt[0]), 32'h0);
        chk("rst_rgnt", 32'(rgnt[0]), 32'h0);
        chk("rst_m_valid", 32'({g_inst[0].m_awvalid, g_inst[0].m_wvalid, g_inst[0].m_arvalid,
                                g_inst[0].m_bready, g_inst[0].m_rready}), 32'h0);
        chk("rst_s_ready", 32'({s_awready[0][0], s_wready[0][0], s_arready[0][1]}), 32'h0);
        s_awvalid[0][0] = 1'b0; s_wvalid[0][0] = 1'b0; s_arvalid[0][1] = 1'b0; s_bready[0][0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single write from master 0.
        c_s1 = g_inst[0].n_s1_rdy;
        fork
            do_write(0, 0, 32'h08, 32'h1234_5678, 0, 0, resp_a, ok_a);
            begin
                @(negedge clk);
                chk("w1_gnt_req_cycle", 32'(wgnt[0]), 32'h0);
                chk("w1_m_awvalid_req_cycle", 32'(g_inst[0].m_awvalid), 32'h0);
                @(negedge clk);
                chk("w1_gnt", 32'(wgnt[0]), 32'h1);
                chk("w1_m_valids", 32'({g_inst[0].m_awvalid, g_inst[0].m_wvalid}), 32'h3);
                chk("w1_m_awaddr", g_inst[0].m_awaddr, 32'h08);
                chk("w1_m_wdata", g_inst[0].m_wdata, 32'h1234_5678);
                chk("w1_m_wstrb", 32'(g_inst[0].m_wstrb), 32'hF);
            end
        join
        chk("w1_done", 32'(ok_a), 32'h1);
        chk("w1_bresp", 32'(resp_a), 32'h0);
        chk("w1_gnt_after", 32'(wgnt[0]), 32'h0);
        chk("w1_s1_quiet", 32'(g_inst[0].n_s1_rdy - c_s1), 32'h0);
        chk("w1_mem", g_inst[0].mem[2], 32'h1234_5678);

        // Round-robin read contention: grants must alternate starting with master 0.
        qs = g_inst[0].rq.size();
        fork
            begin
                logic [31:0] d0;
                bit o0;
                for (int i = 0; i < 3; i++) begin do_read(0, 0, 32'h00, d0, o0); rd0[i] = d0; okr0[i] = o0; end
            end
            begin
                logic [31:0] d1;
                bit o1;
                for (int i = 0; i < 3; i++) begin do_read(0, 1, 32'h04, d1, o1); rd1[i] = d1; okr1[i] = o1; end
            end
        join
        chk("rr_count", 32'(g_inst[0].rq.size() - qs), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("rr_order", 32'(g_inst[0].rq[qs + i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        for (int i = 0; i < 3; i++) begin
            chk("rr_done", 32'({okr0[i], okr1[i]}), 32'h3);
            chk("rr_rdata_m0", rd0[i], 32'h1000_0000);
            chk("rr_rdata_m1", rd1[i], 32'h1000_0001);
        end

        // Fixed priority write contention: master 0 keeps winning while it keeps asking.
        qs = g_inst[1].wq.size();
        fork
            begin
                logic [1:0] r0;
                bit o0;
                for (int i = 0; i < 3; i++) begin
                    do_write(1, 0, 32'h20 + 32'(4 * i), 32'hB000_0000 + 32'(i), 0, 0, r0, o0);
                    wr0[i] = o0 ? r0 : 2'b11;
                end
            end
            begin
                logic [1:0] r1;
                bit o1;
                for (int i = 0; i < 3; i++) begin
                    do_write(1, 1, 32'h30 + 32'(4 * i), 32'hC000_0000 + 32'(i), 0, 0, r1, o1);
                    wr1[i] = o1 ? r1 : 2'b11;
                end
            end
        join
        chk("fp_count", 32'(g_inst[1].wq.size() - qs), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("fp_order", 32'(g_inst[1].wq[qs + i]), (i < 3) ? 32'h1 : 32'h2);
        for (int i = 0; i < 3; i++) chk("fp_bresp", 32'({wr0[i], wr1[i]}), 32'h0);
        chk("fp_mem_m0", g_inst[1].mem[10], 32'hB000_0002);
        chk("fp_mem_m1", g_inst[1].mem[14], 32'hC000_0002);

        // W ahead of AW on master 1: one transfer per channel, single B.
        c_aw = g_inst[0].n_aw; c_w = g_inst[0].n_w; c_b = g_inst[0].n_b;
        fork
            do_write(0, 1, 32'h0C, 32'hA5A5_0001, 3, 0, resp_a, ok_a);
            begin
                @(negedge clk);
                chk("wa_gnt_req_cycle", 32'(wgnt[0]), 32'h0);
                @(negedge clk);
                chk("wa_gnt", 32'(wgnt[0]), 32'h2);
                chk("wa_m_valids", 32'({g_inst[0].m_awvalid, g_inst[0].m_wvalid}), 32'h1);
            end
        join
        chk("wa_done", 32'(ok_a), 32'h1);
        chk("wa_bresp", 32'(resp_a), 32'h0);
        chk("wa_aw_xfers", 32'(g_inst[0].n_aw - c_aw), 32'd1);
        chk("wa_w_xfers", 32'(g_inst[0].n_w - c_w), 32'd1);
        chk("wa_b_xfers", 32'(g_inst[0].n_b - c_b), 32'd1);
        chk("wa_mem", g_inst[0].mem[3], 32'hA5A5_0001);

        // Concurrent read (master 0) and write (master 1) with an error response.
        fork
            do_read(0, 0, 32'h08, rdat, ok_b);
            do_write(0, 1, 32'hFC, 32'hDEAD_BEEF, 0, 0, resp_a, ok_a);
            begin
                @(negedge clk);
                chk("cc_gnt_req_cycle", 32'({wgnt[0], rgnt[0]}), 32'h0);
                @(negedge clk);
                chk("cc_gnts", 32'({wgnt[0], rgnt[0]}), 32'b1001);
            end
        join
        chk("cc_done", 32'({ok_a, ok_b}), 32'h3);
        chk("cc_rdata", rdat, 32'h1234_5678);
        chk("cc_bresp", 32'(resp_a), 32'h2);
        chk("cc_mem", g_inst[0].mem[15], 32'hDEAD_BEEF);

        // Reset while B is pending; master 0 deliberately keeps its valids high.
        c_aw = g_inst[0].n_aw;
        s_awaddr[0][0] = 32'h40; s_wdata[0][0] = 32'h7777_0000; s_wstrb[0][0] = 4'hF;
        s_awvalid[0][0] = 1'b1; s_wvalid[0][0] = 1'b1; s_bready[0][0] = 1'b0;
        for (int i = 0; i < 10 && !s_bvalid[0][0]; i++) @(negedge clk);
        chk("rm_b_pending", 32'(s_bvalid[0][0]), 32'h1);
        chk("rm_gnt_busy", 32'(wgnt[0]), 32'h1);
        chk("rm_no_dup_valid", 32'({g_inst[0].m_awvalid, g_inst[0].m_wvalid}), 32'h0);
        chk("rm_aw_xfers", 32'(g_inst[0].n_aw - c_aw), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rm_gnt", 32'(wgnt[0]), 32'h0);
        chk("rm_s0_out", 32'({s_bvalid[0][0], s_awready[0][0], s_wready[0][0], s_bresp[0][0]}), 32'h0);
        chk("rm_m_out", 32'({g_inst[0].m_awvalid, g_inst[0].m_wvalid, g_inst[0].m_bready}), 32'h0);
        chk("rm_m_addr", g_inst[0].m_awaddr | g_inst[0].m_wdata, 32'h0);
        s_awvalid[0][0] = 1'b0; s_wvalid[0][0] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        qs = g_inst[0].wq.size();
        fork
            do_write(0, 0, 32'h14, 32'h5555_0014, 0, 0, resp_b, ok_b);
            do_write(0, 1, 32'h18, 32'h6666_0018, 0, 0, resp_a, ok_a);
        join
        chk("rs_done", 32'({ok_a, ok_b}), 32'h3);
        chk("rs_bresp", 32'({resp_a, resp_b}), 32'h0);
        chk("rs_first", 32'(g_inst[0].wq[qs]), 32'h1);
        chk("rs_second", 32'(g_inst[0].wq[qs + 1]), 32'h2);
        chk("rs_mem_m1", g_inst[0].mem[6], 32'h6666_0018);
        chk("rs_mem_m0", g_inst[0].mem[5], 32'h5555_0014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
